// File: rtl/raster_position_decoder_if.sv
// Stream bundle for raster_position_decoder: the input pixel beat, the tagged
// output beat and the frame-restart strobe. The slave modport is the decoder
// side and the master modport is the side that drives and observes it.
// Optional signal: border_o, present only when RASTER_BORDER_EN is defined.
//
// Handshake: a beat moves on any rising clock edge where its valid is high and
// the matching ready is high. A valid beat stays stable until it is taken.
interface raster_position_decoder_if #(
   parameter int DATA_WIDTH_P = 8,
   parameter int COORD_W_P    = 10
);
   logic                    resync_i;
   logic                    valid_i;
   logic                    ready_o;
   logic [DATA_WIDTH_P-1:0] data_i;
   logic                    valid_o;
   logic                    ready_i;
   logic [DATA_WIDTH_P-1:0] data_o;
   logic [COORD_W_P-1:0]    col_o;
   logic [COORD_W_P-1:0]    row_o;
   logic                    sol_o;
   logic                    eol_o;
   logic                    sof_o;
   logic                    eof_o;
   logic                    frame_done_o;
`ifdef RASTER_BORDER_EN
   logic                    border_o;
`endif

   modport slave (
      input  resync_i, valid_i, data_i, ready_i,
      output ready_o, valid_o, data_o, col_o, row_o,
             sol_o, eol_o, sof_o, eof_o, frame_done_o
`ifdef RASTER_BORDER_EN
      , output border_o
`endif
   );

   modport master (
      output resync_i, valid_i, data_i, ready_i,
      input  ready_o, valid_o, data_o, col_o, row_o,
             sol_o, eol_o, sof_o, eof_o, frame_done_o
`ifdef RASTER_BORDER_EN
      , input border_o
`endif
   );
endinterface

// File: rtl/raster_position_decoder.sv
// raster_position_decoder: takes a raster-order pixel stream and tags each beat
// with its column/row and line/frame markers through one registered stage
// that keeps full throughput under backpressure.
// Optional feature: define RASTER_BORDER_EN to add border_o, which marks beats
// on the outer ring of the frame.
module raster_position_decoder #(
   parameter int DATA_WIDTH_P = 8,
   parameter int FRAME_W_P    = 640,
   parameter int FRAME_H_P    = 480,
   parameter int COORD_W_P    = 10
) (
   input logic                     clk_i,
   input logic                     rstn_i,
   raster_position_decoder_if.slave bus
);
   localparam logic [COORD_W_P-1:0] COL_LAST = COORD_W_P'(FRAME_W_P - 1);
   localparam logic [COORD_W_P-1:0] ROW_LAST = COORD_W_P'(FRAME_H_P - 1);
   localparam logic [COORD_W_P-1:0] COORD_ONE = COORD_W_P'(1);

   logic                 accept;
   logic [COORD_W_P-1:0] col_cnt;
   logic [COORD_W_P-1:0] row_cnt;
   logic [COORD_W_P-1:0] tag_col;
   logic [COORD_W_P-1:0] tag_row;
   logic                 tag_eol;
   logic                 tag_last_row;

   // The stage can take a beat when it is empty or its beat leaves this cycle.
   assign bus.ready_o = ~bus.valid_o | bus.ready_i;
   assign accept      = bus.valid_i & bus.ready_o;

   // Position of the beat being accepted; a resync in the same cycle makes it
   // the first pixel of a fresh frame.
   always_comb begin
      tag_col = col_cnt;
      tag_row = row_cnt;
      if (bus.resync_i) begin
         tag_col = '0;
         tag_row = '0;
      end
      tag_eol      = (tag_col == COL_LAST);
      tag_last_row = (tag_row == ROW_LAST);
   end

   // Raster counters: step past the tagged position on accept, else resync clears.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (tag_eol) begin
            col_cnt <= '0;
            row_cnt <= tag_last_row ? '0 : tag_row + COORD_ONE;
         end else begin
            col_cnt <= tag_col + COORD_ONE;
            row_cnt <= tag_row;
         end
      end else if (bus.resync_i) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end
   end

   // Output register: load on accept, drain when taken, otherwise hold.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bus.valid_o <= 1'b0;
         bus.data_o  <= '0;
         bus.col_o   <= '0;
         bus.row_o   <= '0;
         bus.sol_o   <= 1'b0;
         bus.eol_o   <= 1'b0;
         bus.sof_o   <= 1'b0;
         bus.eof_o   <= 1'b0;
      end else if (accept) begin
         bus.valid_o <= 1'b1;
         bus.data_o  <= bus.data_i;
         bus.col_o   <= tag_col;
         bus.row_o   <= tag_row;
         bus.sol_o   <= (tag_col == '0);
         bus.eol_o   <= tag_eol;
         bus.sof_o   <= (tag_col == '0) && (tag_row == '0);
         bus.eof_o   <= tag_eol && tag_last_row;
      end else if (bus.ready_i) begin
         bus.valid_o <= 1'b0;
      end
   end

   // Frame-done pulse in the cycle after the last pixel of a frame is taken.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bus.frame_done_o <= 1'b0;
      end else begin
         bus.frame_done_o <= bus.valid_o & bus.ready_i & bus.eof_o;
      end
   end

`ifdef RASTER_BORDER_EN
   // Border marker travels with the beat and holds while it is stalled.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bus.border_o <= 1'b0;
      end else if (accept) begin
         bus.border_o <= (tag_row == '0) || tag_last_row || (tag_col == '0) || tag_eol;
      end
   end
`endif
endmodule

// File: tb/tb_raster_position_decoder.sv
// Testbench for raster_position_decoder on a 4x3 frame. A behavioural model
// tracks the linear pixel index of the stream and is compared with the DUT
// every cycle; directed phases add literal checks on the consumed beats.
module tb_raster_position_decoder;
   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int CW = 2;
   localparam int BW = DW + 2 * CW + 5;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   raster_position_decoder_if #(.DATA_WIDTH_P(DW), .COORD_W_P(CW)) bus ();

   raster_position_decoder #(
      .DATA_WIDTH_P(DW),
      .FRAME_W_P   (W),
      .FRAME_H_P   (H),
      .COORD_W_P   (CW)
   ) dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic dut_border;
`ifdef RASTER_BORDER_EN
   assign dut_border = bus.border_o;
`else
   assign dut_border = 1'b0;
`endif

   logic [BW-1:0] dut_vec;
   assign dut_vec = {bus.data_o, bus.col_o, bus.row_o, bus.sol_o, bus.eol_o,
                     bus.sof_o, bus.eof_o, dut_border};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int f_data(input logic [BW-1:0] v); return int'(v[BW-1 -: DW]); endfunction
   function automatic int f_col(input logic [BW-1:0] v);  return int'(v[BW-DW-1 -: CW]); endfunction
   function automatic int f_row(input logic [BW-1:0] v);  return int'(v[BW-DW-CW-1 -: CW]); endfunction

   // ---------------- scoreboard / model ----------------
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] obs_q[$];
   int pos = 0;
   bit fd_pend = 0;
   int fd_count = 0;

   function automatic logic [BW-1:0] model_beat(input int d, input int p);
      int c, r;
      bit brd;
      c = p % W;
      r = p / W;
`ifdef RASTER_BORDER_EN
      brd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
`else
      brd = 1'b0;
`endif
      return {DW'(d), CW'(c), CW'(r), c == 0, c == W - 1, p == 0, p == W * H - 1, brd};
   endfunction

   always @(negedge clk) begin
      bit acc, cons;
      logic [BW-1:0] front;
      if (!rstn) begin
         exp_q.delete();
         pos     = 0;
         fd_pend = 0;
         chk("rst_valid", int'(bus.valid_o), 0);
         chk("rst_frame_done", int'(bus.frame_done_o), 0);
      end else begin
         chk("valid", int'(bus.valid_o), (exp_q.size() > 0) ? 1 : 0);
         chk("ready", int'(bus.ready_o), (exp_q.size() == 0 || bus.ready_i) ? 1 : 0);
         chk("frame_done", int'(bus.frame_done_o), int'(fd_pend));
         if (bus.frame_done_o) fd_count++;
         acc     = bus.valid_i & bus.ready_o;
         cons    = bus.valid_o & bus.ready_i;
         fd_pend = 0;
         if (exp_q.size() > 0 && bus.valid_o) begin
            front = exp_q[0];
            checks++;
            if (dut_vec !== front) begin
               errors++;
               $display("FAIL beat actual=%h expected=%h at %0t", dut_vec, front, $time);
            end
            if (cons) begin
               void'(exp_q.pop_front());
               obs_q.push_back(dut_vec);
               fd_pend = front[1];
            end
         end
         if (acc) begin
            if (bus.resync_i) pos = 0;
            exp_q.push_back(model_beat(int'(bus.data_i), pos));
            pos = (pos + 1) % (W * H);
         end else if (bus.resync_i) begin
            pos = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int d, input bit rs);
      bit done;
      done = 0;
      bus.valid_i  = 1'b1;
      bus.data_i   = DW'(d);
      bus.resync_i = rs;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         done = bus.ready_o;
         @(posedge clk);
         #2;
      end
      if (!done) chk("send_timeout", 0, 1);
      bus.valid_i  = 1'b0;
      bus.resync_i = 1'b0;
   endtask

   task automatic resync_pulse();
      bus.resync_i = 1'b1;
      step();
      bus.resync_i = 1'b0;
   endtask

   task automatic chk_obs(input string name, input int idx, input int d, input int c,
                          input int r, input int sof);
      if (idx >= obs_q.size()) begin
         chk({name, "_missing"}, obs_q.size(), idx + 1);
      end else begin
         chk({name, "_data"}, f_data(obs_q[idx]), d);
         chk({name, "_col"}, f_col(obs_q[idx]), c);
         chk({name, "_row"}, f_row(obs_q[idx]), r);
         chk({name, "_sof"}, int'(obs_q[idx][2]), sof);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed phases ----------------
   initial begin
      int base, fd0;
      logic [12:0] col_tab [0:12];
      int row_tab [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
      int c_tab   [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
      logic [12:0] sol_m, eol_m, sof_m, eof_m;
      logic [11:0] brd_m;
      sol_m = 13'b1_0001_0001_0001;
      eol_m = 13'b0_1000_1000_1000;
      sof_m = 13'b1_0000_0000_0001;
      eof_m = 13'b0_1000_0000_0000;
      brd_m = 12'b1111_1001_1111;
      col_tab[0] = '0;

      bus.valid_i  = 1'b0;
      bus.data_i   = '0;
      bus.ready_i  = 1'b0;
      bus.resync_i = 1'b0;

      // Reset for two cycles
      #1 rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
      #1;
      chk("reset_valid_o", int'(bus.valid_o), 0);
      chk("reset_ready_o", int'(bus.ready_o), 1);
      chk("reset_frame_done", int'(bus.frame_done_o), 0);

      // Full frame streaming, then a 13th beat
      bus.ready_i = 1'b1;
      base = obs_q.size();
      fd0  = fd_count;
      for (int i = 0; i < 12; i++) send(i, 1'b0);
      repeat (3) step();
      chk("frame_done_pulses", fd_count - fd0, 1);
      send(12, 1'b0);
      repeat (3) step();
      for (int i = 0; i < 13; i++) begin
         chk_obs("stream", base + i, i, c_tab[i], row_tab[i], int'(sof_m[i]));
         if (base + i < obs_q.size()) begin
            chk("stream_sol", int'(obs_q[base + i][4]), int'(sol_m[i]));
            chk("stream_eol", int'(obs_q[base + i][3]), int'(eol_m[i]));
            chk("stream_eof", int'(obs_q[base + i][1]), int'(eof_m[i]));
         end
      end

      // Backpressure on beat 5 at (1,1)
      resync_pulse();
      for (int i = 0; i < 6; i++) send(i, 1'b0);
      bus.ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_data", int'(bus.data_o), 5);
         chk("stall_col", int'(bus.col_o), 1);
         chk("stall_row", int'(bus.row_o), 1);
         chk("stall_ready_o", int'(bus.ready_o), 0);
         @(posedge clk);
         #2;
      end
      bus.ready_i = 1'b1;
      base = obs_q.size();
      send(6, 1'b0);
      repeat (3) step();
      chk_obs("bp_beat5", base, 5, 1, 1, 0);
      chk_obs("bp_beat6", base + 1, 6, 2, 1, 0);

      // Resync with and without a coincident accept
      resync_pulse();
      base = obs_q.size();
      send(20, 1'b0);
      send(21, 1'b1);
      send(22, 1'b0);
      repeat (3) step();
      chk_obs("resync_idle", base, 20, 0, 0, 1);
      chk_obs("resync_acc", base + 1, 21, 0, 0, 1);
      chk_obs("resync_next", base + 2, 22, 1, 0, 0);

      // Reset while a beat is held mid-frame
      send(30, 1'b0);
      bus.ready_i = 1'b0;
      step();
      rstn = 1'b0;
      #1;
      chk("midrst_valid_o", int'(bus.valid_o), 0);
      step();
      rstn = 1'b1;
      bus.ready_i = 1'b1;
      base = obs_q.size();
      send(40, 1'b0);
      repeat (3) step();
      chk_obs("after_rst", base, 40, 0, 0, 1);

`ifdef RASTER_BORDER_EN
      // Border marker across a full frame
      resync_pulse();
      base = obs_q.size();
      for (int i = 0; i < 12; i++) send(50 + i, 1'b0);
      repeat (3) step();
      for (int i = 0; i < 12; i++) begin
         if (base + i < obs_q.size())
            chk("border", int'(obs_q[base + i][0]), int'(brd_m[i]));
         else
            chk("border_missing", obs_q.size(), base + i + 1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
